// File: rtl/lsu_ahb.sv
// lsu_ahb: load/store unit for the veriRISCV core, acting as an AHB-Lite master
// on the data bus. It takes one load or store at a time from the MEM stage
// over a valid/ready handshake and returns a single-cycle response pulse.
//
// Ports
//   clk, rst             core clock; asynchronous active-low reset
//   lsu_req_vld/rdy      request handshake (rdy only while IDLE)
//   lsu_mem_wr           1 = store, 0 = load
//   lsu_mem_op           [1:0] 00 byte, 01 half, 10 word; [2] = unsigned load
//   lsu_addr, lsu_wdata  byte address, right-aligned store data
//   lsu_rsp_vld          one-cycle response pulse
//   lsu_rdata            extended load data
//   exc_*                exception flags, valid with lsu_rsp_vld
//   dbus_*               AHB-Lite master interface
module lsu_ahb #(
  parameter int unsigned AW             = 32,
  parameter bit          MISALIGN_SPLIT = 1'b0,
  parameter logic [3:0]  HPROT          = 4'b0001
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_req_vld,
  output logic          lsu_req_rdy,
  input  logic          lsu_mem_wr,
  input  logic [2:0]    lsu_mem_op,
  input  logic [31:0]   lsu_addr,
  input  logic [31:0]   lsu_wdata,
  output logic          lsu_rsp_vld,
  output logic [31:0]   lsu_rdata,
  output logic          exc_load_addr_misaligned,
  output logic          exc_store_addr_misaligned,
  output logic          exc_load_access_fault,
  output logic          exc_store_access_fault,
  output logic          dbus_hwrite,
  output logic [2:0]    dbus_hsize,
  output logic [2:0]    dbus_hburst,
  output logic [3:0]    dbus_hprot,
  output logic [1:0]    dbus_htrans,
  output logic          dbus_hmastlock,
  output logic [AW-1:0] dbus_haddr,
  output logic [31:0]   dbus_hwdata,
  input  logic          dbus_hready,
  input  logic          dbus_hresp,
  input  logic [31:0]   dbus_hrdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR1,
    S_DATA1,
    S_ADDR2,
    S_DATA2,
    S_RESP
  } state_t;

  state_t      state_q, state_d;

  logic        wr_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic        split_q;
  logic        cross_q;
  logic        exc_lm_q, exc_sm_q, exc_lf_q, exc_sf_q;
  logic [31:0] word0_q;
  logic [31:0] rdata_q;
  logic [31:0] hwdata_q;

  logic        accept;
  logic        req_misal, req_split, req_cross;
  logic [31:0] wdata_rep;
  logic        data_done;
  logic [63:0] raw;
  logic [31:0] sel;
  logic [31:0] load_data;
  logic [31:0] aligned_addr;
  logic [31:0] haddr_full;

  assign lsu_req_rdy = rst & (state_q == S_IDLE);
  assign accept      = lsu_req_vld & lsu_req_rdy;

  // Request decode on the live inputs; registered only on acceptance.
  always_comb begin
    req_misal = lsu_mem_op[1] ? (|lsu_addr[1:0]) : (lsu_mem_op[0] & lsu_addr[0]);
    req_split = req_misal & ~lsu_mem_wr & MISALIGN_SPLIT;
    req_cross = lsu_mem_op[1] ? (|lsu_addr[1:0]) : (lsu_mem_op[0] & (&lsu_addr[1:0]));
    unique case (lsu_mem_op[1:0])
      2'b00:   wdata_rep = {4{lsu_wdata[7:0]}};
      2'b01:   wdata_rep = {2{lsu_wdata[15:0]}};
      default: wdata_rep = lsu_wdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = (req_misal && !req_split) ? S_RESP : S_ADDR1;
      S_ADDR1: if (dbus_hready) state_d = S_DATA1;
      S_DATA1: if (dbus_hready)
                 state_d = (!dbus_hresp && split_q && cross_q) ? S_ADDR2 : S_RESP;
      S_ADDR2: if (dbus_hready) state_d = S_DATA2;
      S_DATA2: if (dbus_hready) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign data_done = dbus_hready & ((state_q == S_DATA1) | (state_q == S_DATA2));

  // Loads are extracted from a little-endian 64-bit window: the second word
  // of a split access sits above the first, so one byte shift by the
  // original address offset covers aligned, single-read and split cases.
  always_comb begin
    raw = (state_q == S_DATA2) ? {dbus_hrdata, word0_q} : {32'h0, dbus_hrdata};
    sel = raw[{1'b0, addr_q[1:0], 3'b000} +: 32];
    if (op_q[1])
      load_data = sel;
    else if (op_q[0])
      load_data = {{16{~op_q[2] & sel[15]}}, sel[15:0]};
    else
      load_data = {{24{~op_q[2] & sel[7]}}, sel[7:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      split_q  <= 1'b0;
      cross_q  <= 1'b0;
      exc_lm_q <= 1'b0;
      exc_sm_q <= 1'b0;
      exc_lf_q <= 1'b0;
      exc_sf_q <= 1'b0;
      word0_q  <= '0;
      rdata_q  <= '0;
      hwdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q     <= lsu_mem_wr;
        op_q     <= lsu_mem_op;
        addr_q   <= lsu_addr;
        split_q  <= req_split;
        cross_q  <= req_cross;
        exc_lm_q <= req_misal & ~lsu_mem_wr & ~req_split;
        exc_sm_q <= req_misal & lsu_mem_wr;
        exc_lf_q <= 1'b0;
        exc_sf_q <= 1'b0;
        rdata_q  <= '0;
        hwdata_q <= wdata_rep;
      end
      if (data_done) begin
        if (dbus_hresp) begin
          exc_lf_q <= ~wr_q;
          exc_sf_q <= wr_q;
        end else if (!wr_q) begin
          if (state_q == S_DATA1 && split_q && cross_q)
            word0_q <= dbus_hrdata;
          else
            rdata_q <= load_data;
        end
      end
    end
  end

  always_comb begin
    aligned_addr = {addr_q[31:2], 2'b00};
    if (!split_q)
      haddr_full = addr_q;
    else if (state_q == S_ADDR2)
      haddr_full = aligned_addr + 32'd4;
    else
      haddr_full = aligned_addr;
  end

  assign dbus_haddr     = haddr_full[AW-1:0];
  assign dbus_htrans    = ((state_q == S_ADDR1) || (state_q == S_ADDR2)) ? 2'b10 : 2'b00;
  assign dbus_hwrite    = wr_q;
  assign dbus_hsize     = split_q ? 3'b010 : {1'b0, (op_q[1] ? 2'b10 : op_q[1:0])};
  assign dbus_hburst    = 3'b000;
  assign dbus_hprot     = HPROT;
  assign dbus_hmastlock = 1'b0;
  assign dbus_hwdata    = hwdata_q;

  assign lsu_rsp_vld               = (state_q == S_RESP);
  assign lsu_rdata                 = rdata_q;
  assign exc_load_addr_misaligned  = exc_lm_q & lsu_rsp_vld;
  assign exc_store_addr_misaligned = exc_sm_q & lsu_rsp_vld;
  assign exc_load_access_fault     = exc_lf_q & lsu_rsp_vld;
  assign exc_store_access_fault    = exc_sf_q & lsu_rsp_vld;

endmodule

// File: tb/tb_lsu_ahb.sv
// Testbench for lsu_ahb: two instances (hardware split off / on) share the
// request fields and the AHB slave inputs; only one is active at a time.
// The bench acts as the AHB slave over a byte-addressed memory model.
module tb_lsu_ahb;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req_vld [2];
  logic        req_rdy [2];
  logic        mem_wr;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        rsp_vld [2];
  logic [31:0] rdata   [2];
  logic        elm [2], esm [2], elf [2], esf [2];
  logic        hwrite  [2];
  logic [2:0]  hsize   [2];
  logic [2:0]  hburst  [2];
  logic [3:0]  hprot   [2];
  logic [1:0]  htrans  [2];
  logic        hmastlock [2];
  logic [31:0] haddr   [2];
  logic [31:0] hwdata  [2];
  logic        hready, hresp;
  logic [31:0] hrdata;

  lsu_ahb #(.AW(32), .MISALIGN_SPLIT(1'b0), .HPROT(4'b0001)) dut0 (
    .clk(clk), .rst(rst),
    .lsu_req_vld(req_vld[0]), .lsu_req_rdy(req_rdy[0]),
    .lsu_mem_wr(mem_wr), .lsu_mem_op(mem_op), .lsu_addr(addr), .lsu_wdata(wdata),
    .lsu_rsp_vld(rsp_vld[0]), .lsu_rdata(rdata[0]),
    .exc_load_addr_misaligned(elm[0]), .exc_store_addr_misaligned(esm[0]),
    .exc_load_access_fault(elf[0]), .exc_store_access_fault(esf[0]),
    .dbus_hwrite(hwrite[0]), .dbus_hsize(hsize[0]), .dbus_hburst(hburst[0]),
    .dbus_hprot(hprot[0]), .dbus_htrans(htrans[0]), .dbus_hmastlock(hmastlock[0]),
    .dbus_haddr(haddr[0]), .dbus_hwdata(hwdata[0]),
    .dbus_hready(hready), .dbus_hresp(hresp), .dbus_hrdata(hrdata)
  );

  lsu_ahb #(.AW(32), .MISALIGN_SPLIT(1'b1), .HPROT(4'b0001)) dut1 (
    .clk(clk), .rst(rst),
    .lsu_req_vld(req_vld[1]), .lsu_req_rdy(req_rdy[1]),
    .lsu_mem_wr(mem_wr), .lsu_mem_op(mem_op), .lsu_addr(addr), .lsu_wdata(wdata),
    .lsu_rsp_vld(rsp_vld[1]), .lsu_rdata(rdata[1]),
    .exc_load_addr_misaligned(elm[1]), .exc_store_addr_misaligned(esm[1]),
    .exc_load_access_fault(elf[1]), .exc_store_access_fault(esf[1]),
    .dbus_hwrite(hwrite[1]), .dbus_hsize(hsize[1]), .dbus_hburst(hburst[1]),
    .dbus_hprot(hprot[1]), .dbus_htrans(htrans[1]), .dbus_hmastlock(hmastlock[1]),
    .dbus_haddr(haddr[1]), .dbus_hwdata(hwdata[1]),
    .dbus_hready(hready), .dbus_hresp(hresp), .dbus_hrdata(hrdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] word_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return {mem_rd(wa + 3), mem_rd(wa + 2), mem_rd(wa + 1), mem_rd(wa)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Runs one request on instance d and plays the AHB slave. waits = hready-low
  // cycles per data phase; err_x = 1-based transfer that answers with ERROR.
  task automatic run_txn(input int d, input bit wr, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input int err_x,
                         output int lat, output logic [31:0] rd);
    int n, off, nx_exp, nx, c, wl, exp_lat;
    bit mis, split, exc_mis, fault, dp, dp_err, done;
    logic [31:0] xa [2];
    logic [31:0] exp_rd, exp_hw, dp_a;
    logic [2:0]  exp_sz;

    n       = op[1] ? 4 : (op[0] ? 2 : 1);
    off     = int'(a[1:0]);
    mis     = (n == 2 && a[0]) || (n == 4 && off != 0);
    split   = mis && !wr && d == 1;
    exc_mis = mis && !split;
    nx_exp  = exc_mis ? 0 : ((split && off + n > 4) ? 2 : 1);
    if (err_x > nx_exp) err_x = 0;
    fault = (err_x != 0);
    if (err_x == 1) nx_exp = 1;
    xa[0]  = split ? {a[31:2], 2'b00} : a;
    xa[1]  = {a[31:2], 2'b00} + 32'd4;
    exp_sz = split ? 3'b010 : (n == 4 ? 3'b010 : (n == 2 ? 3'b001 : 3'b000));
    exp_hw = (n == 1) ? {4{wd[7:0]}} : ((n == 2) ? {2{wd[15:0]}} : wd);
    exp_rd = '0;
    if (!wr && !exc_mis && !fault) begin
      for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = mem_rd(a + i);
      if (!op[2] && n == 1) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
      if (!op[2] && n == 2) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
    end
    exp_lat = 1;
    for (int k = 0; k < nx_exp; k++)
      exp_lat += 2 + ((k + 1 == err_x && waits == 0) ? 1 : waits);

    mem_wr = wr; mem_op = op; addr = a; wdata = wd;
    req_vld[d] = 1'b1;
    chk("req_rdy_idle", {31'b0, req_rdy[d]}, 32'd1);
    @(posedge clk); #1;
    req_vld[d] = 1'b0;
    c = 1; nx = 0; dp = 0; dp_err = 0; wl = 0; dp_a = '0; done = 0;
    while (c <= 40) begin
      if (rsp_vld[d]) begin
        done = 1;
        break;
      end
      hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
      if (dp) begin
        if (wl > 0) begin
          hready = 1'b0;
          hresp  = dp_err && wl == 1;
          wl--;
        end else begin
          if (wr) chk("hwdata", hwdata[d], exp_hw);
          if (dp_err) hresp = 1'b1;
          else if (!wr) hrdata = word_rd(dp_a);
          dp = 0;
        end
      end
      if (htrans[d] == 2'b10 && hready) begin
        if (nx < 2) chk("haddr", haddr[d], xa[nx]);
        chk("hsize", {29'b0, hsize[d]}, {29'b0, exp_sz});
        chk("hwrite", {31'b0, hwrite[d]}, {31'b0, wr});
        chk("hburst_hprot_hlock", {24'b0, hburst[d], hprot[d], hmastlock[d]}, {24'b0, 3'b000, 4'b0001, 1'b0});
        nx++;
        dp     = 1;
        dp_a   = haddr[d];
        dp_err = (nx == err_x);
        wl     = (dp_err && waits == 0) ? 1 : waits;
      end
      @(posedge clk); #1;
      c++;
    end
    hready = 1'b1; hresp = 1'b0;
    lat = c;
    rd  = rdata[d];
    if (!done) begin
      chk("rsp_timeout", 32'(c), 32'(exp_lat));
      rst = 1'b0; #2; rst = 1'b1;
      @(posedge clk); #1;
      return;
    end
    chk("latency", 32'(c), 32'(exp_lat));
    chk("nonseq_count", 32'(nx), 32'(nx_exp));
    chk("exc_flags", {28'b0, elm[d], esm[d], elf[d], esf[d]},
        {28'b0, exc_mis && !wr, exc_mis && wr, fault && !wr, fault && wr});
    if (!wr) chk("rdata", rdata[d], exp_rd);
    if (wr && !exc_mis && !fault)
      for (int i = 0; i < n; i++) mem[a + i] = wd[8*i +: 8];
    @(posedge clk); #1;
    chk("rsp_one_cycle", {31'b0, rsp_vld[d]}, 32'd0);
    chk("req_rdy_after", {31'b0, req_rdy[d]}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    rst = 1'b0;
    req_vld[0] = 1'b0; req_vld[1] = 1'b0;
    mem_wr = 1'b0; mem_op = '0; addr = '0; wdata = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", {31'b0, req_rdy[d]}, 32'd0);
      chk("rst_htrans", {30'b0, htrans[d]}, 32'd0);
      chk("rst_rsp", {31'b0, rsp_vld[d]}, 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
      chk("rst_hwdata", hwdata[d], 32'd0);
      chk("rst_exc", {28'b0, elm[d], esm[d], elf[d], esf[d]}, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // LB / LBU at 0x1003
    mem[32'h1000] = 8'h11; mem[32'h1001] = 8'h22; mem[32'h1002] = 8'h33; mem[32'h1003] = 8'h80;
    run_txn(0, 1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, lat, rd);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_data", rd, 32'hFFFF_FF80);
    run_txn(0, 1'b0, 3'b100, 32'h1003, 32'h0, 0, 0, lat, rd);
    chk("lbu_data", rd, 32'h0000_0080);

    // SH with two wait states
    run_txn(0, 1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 2, 0, lat, rd);
    chk("sh_lat", 32'(lat), 32'd5);
    chk("sh_mem", {mem_rd(32'h2003), mem_rd(32'h2002)}, 32'h0000_BEEF);

    // Split misaligned word load
    mem[32'h1000] = 8'h11; mem[32'h1001] = 8'h22; mem[32'h1002] = 8'h33; mem[32'h1003] = 8'h44;
    mem[32'h1004] = 8'h55; mem[32'h1005] = 8'h66; mem[32'h1006] = 8'h77; mem[32'h1007] = 8'h88;
    run_txn(1, 1'b0, 3'b010, 32'h1002, 32'h0, 0, 0, lat, rd);
    chk("split_lw_data", rd, 32'h6655_4433);
    chk("split_lw_lat", 32'(lat), 32'd5);

    // Misaligned without split
    run_txn(0, 1'b0, 3'b010, 32'h1002, 32'h0, 0, 0, lat, rd);
    chk("mis_lw_lat", 32'(lat), 32'd1);
    run_txn(0, 1'b1, 3'b010, 32'h1001, 32'hDEAD_BEEF, 0, 0, lat, rd);
    chk("mis_sw_lat", 32'(lat), 32'd1);

    // Two-cycle error response
    run_txn(0, 1'b0, 3'b010, 32'h3000, 32'h0, 1, 1, lat, rd);
    chk("fault_lat", 32'(lat), 32'd4);
    chk("fault_rdata", rd, 32'd0);

    // Reset during DATA1 of a store
    mem_wr = 1'b1; mem_op = 3'b010; addr = 32'h4000; wdata = 32'hCAFE_F00D;
    req_vld[0] = 1'b1;
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    chk("mid_addr_phase", {30'b0, htrans[0]}, 32'd2);
    @(posedge clk); #1;
    hready = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_htrans", {30'b0, htrans[0]}, 32'd0);
    chk("mid_rst_rsp", {31'b0, rsp_vld[0]}, 32'd0);
    chk("mid_rst_rdy", {31'b0, req_rdy[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; hready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_rsp", {31'b0, rsp_vld[0]}, 32'd0);
      chk("post_rst_rdy", {31'b0, req_rdy[0]}, 32'd1);
    end
    run_txn(0, 1'b0, 3'b010, 32'h1000, 32'h0, 0, 0, lat, rd);
    chk("post_rst_lw", rd, 32'h4433_2211);

    // Randomized traffic on both instances
    for (int t = 0; t < 80; t++) begin
      int d, sz, wt, ex;
      bit w;
      logic [2:0]  op;
      logic [31:0] a;
      d  = int'($urandom_range(0, 1));
      w  = ($urandom_range(0, 2) == 0);
      sz = int'($urandom_range(0, 2));
      op = {(w ? 1'b0 : 1'($urandom_range(0, 1))), 2'(sz)};
      a  = 32'h5000 + $urandom_range(0, 63);
      wt = int'($urandom_range(0, 2));
      ex = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_txn(d, w, op, a, $urandom, wt, ex, lat, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ahb.md
Name: lsu_ahb

Overview:
Parametrised load/store unit for the veriRISCV core. It accepts one load or store from the MEM stage through a valid/ready handshake and runs it as a full AHB-Lite master on the data bus, honouring hready wait states and hresp errors. It returns aligned, sign- or zero-extended load data and reports misaligned-address and access-fault exceptions. With MISALIGN_SPLIT=1 it can split a word-crossing misaligned load into two aligned word reads.

Parameters:
AW, 32, dbus_haddr width; lsu_addr[AW-1:0] drives the bus.
MISALIGN_SPLIT, 0, 1 = service misaligned loads in hardware; 0 = raise exc_load_addr_misaligned.
HPROT, 4'b0001, constant driven on dbus_hprot.

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low
lsu_req_vld  in  1  request valid
lsu_req_rdy  out  1  request accepted when vld&rdy
lsu_mem_wr  in  1  1=store, 0=load
lsu_mem_op  in  3  [1:0] 00 byte, 01 half, 10 word; [2]=1 unsigned load
lsu_addr  in  32  byte address
lsu_wdata  in  32  store data, right-aligned
lsu_rsp_vld  out  1  one-cycle response pulse, for loads and stores
lsu_rdata  out  32  extended load data, valid with lsu_rsp_vld on a load
exc_load_addr_misaligned, exc_store_addr_misaligned, exc_load_access_fault, exc_store_access_fault  out  1 each  valid with lsu_rsp_vld
dbus_hwrite out 1; dbus_hsize out 3; dbus_hburst out 3 (000); dbus_hprot out 4; dbus_htrans out 2; dbus_hmastlock out 1 (0); dbus_haddr out AW; dbus_hwdata out 32
dbus_hready in 1; dbus_hresp in 1; dbus_hrdata in 32

Behaviour:
- Reset (rst=0, async): state IDLE; htrans=IDLE(00); lsu_rsp_vld, all exc_* = 0; lsu_rdata, hwdata = 0; lsu_req_rdy=0 while in reset.
- Only one transaction is outstanding. lsu_req_rdy=1 only in IDLE. The request is registered on acceptance.
- FSM: IDLE -> ADDR1 -> DATA1 -> [ADDR2 -> DATA2] -> RESP -> IDLE.
  - ADDR1/ADDR2: htrans=NONSEQ(10) with haddr/hsize/hwrite stable; leave on hready=1.
  - DATA1/DATA2: htrans=IDLE; hwdata stable; leave on hready=1.
  - RESP: lsu_rsp_vld=1 for exactly one cycle.
- Zero-wait-state latency: accept at cycle T, address phase T+1, data phase T+2, lsu_rsp_vld at T+3. Each hready-low cycle adds one cycle.
- Misaligned check at acceptance: half needs addr[0]=0; word needs addr[1:0]=00; byte is never misaligned.
  - Misaligned store: no bus transfer; IDLE->RESP; exc_store_addr_misaligned=1.
  - Misaligned load with MISALIGN_SPLIT=0: same path, with exc_load_addr_misaligned=1.
  - Misaligned load with MISALIGN_SPLIT=1: read aligned words with hsize=010.
    - Access within one word (half at offset 1): one read.
    - Access crossing a word (half at offset 3; word at offset 1/2/3): second read at aligned addr+4.
    - Combine little-endian bytes from both words; no exception raised.
- Aligned accesses: haddr=lsu_addr; hsize=000/001/010 from op[1:0]. hwdata replicates the byte/half across all lanes (byte x4, half x2).
- Load data: select the byte/half from hrdata by address offset. Sign-extend unless op[2]=1. Capture hrdata on the hready=1 data-phase cycle.
- hresp=1 with hready=1 in a data phase ends the transfer and sets exc_load_access_fault or exc_store_access_fault in RESP.
  - A DATA1 error skips ADDR2.
  - lsu_rdata is 0 on fault.
- hresp with hready=0 (first error cycle) only waits.
- lsu_req_vld with lsu_req_rdy=0 is ignored; the requester holds it.
- Reset asserted mid-transaction returns to IDLE immediately, drives htrans=IDLE, and produces no response.

Test Plan:
- LB at 0x1003 with op=000 and hrdata=0x80332211, no wait states -> lsu_rsp_vld at T+3, lsu_rdata=0xFFFFFF80; LBU (op=100) -> 0x00000080.
- SH at 0x2002 with wdata=0x0000BEEF -> haddr=0x2002, hsize=001, hwrite=1, hwdata=0xBEEFBEEF; hready low 2 cycles in DATA1 -> lsu_rsp_vld at T+5, no exc.
- MISALIGN_SPLIT=1, LW at 0x1002, reads return 0x44332211 (haddr 0x1000) then 0x88776655 (haddr 0x1004) -> two NONSEQ transfers, lsu_rdata=0x66554433.
- MISALIGN_SPLIT=0, LW at 0x1002 -> no NONSEQ ever driven, lsu_rsp_vld at T+1 (accept cycle T) with exc_load_addr_misaligned=1; SW at 0x1001 -> exc_store_addr_misaligned=1.
- LW at 0x3000, slave drives hresp=1/hready=0 then hresp=1/hready=1 -> exc_load_access_fault=1, lsu_rdata=0, lsu_req_rdy returns to 1 the following cycle.
- rst driven low during DATA1 of a store -> htrans=00, lsu_rsp_vld stays 0, FSM IDLE; after release, a new LW completes normally.
